display7seg_reader: RTL and testbench
=====================================

DISPLAY7SEG_READER -- requirements
Module: display7seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, range 2..255; number of consecutive cycles a sampled (an, segment) pair must persist before capture.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Ports: a, b, c, d, e, f, g  input  1 each  segment lines of a multiplexed 4-digit display, active-low (0 = lit).
REQ-005 Port: an  input  4  digit enables, active-low; an[i]=0 selects digit i.
REQ-006 Port: digits  output  16  decoded hex values; digits[4i+3:4i] belongs to digit i.
REQ-007 Port: digit_valid  output  4  bit i = 1 when digits[4i+3:4i] holds a value from a recognised pattern.
REQ-008 Port: err  output  1  one-cycle pulse on capture of an unrecognised, non-blank pattern.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last pulse.

Function
REQ-010 The block SHALL register {an, a..g} into a sample register every cycle; all decisions use the sample register only.
REQ-011 The block SHALL implement FSM states WAIT, COUNT and HELD.
REQ-012 WAIT: if the sample an has exactly one bit low, go to COUNT with cnt=1; otherwise stay in WAIT.
REQ-013 COUNT: if the sample equals the previous sample, increment cnt; when cnt reaches STABLE_CYCLES, capture and go to HELD.
REQ-014 COUNT: if the sample differs from the previous sample, go to COUNT with cnt=1 if the new an is one-hot-low; otherwise go to WAIT with cnt=0.
REQ-015 HELD: no further capture; on any change of the sample, apply the REQ-014 rule.
REQ-016 Latency: an input pair held stable from edge k SHALL be captured, and outputs updated, at edge k+STABLE_CYCLES.
REQ-017 Decode table {a..g}->value: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
REQ-018 Capture of a table pattern SHALL write the value into digit i and set digit_valid[i].
REQ-019 Capture of blank 1111111 SHALL clear digit_valid[i], leave the digit value unchanged and not pulse err.
REQ-020 Capture of any other pattern SHALL clear digit_valid[i], leave the digit value unchanged and pulse err for one cycle.
REQ-021 Every capture (recognised, blank or error) SHALL set bit i of an internal capture mask.
REQ-022 On the edge the mask becomes 1111, frame_valid SHALL pulse for one cycle and the mask SHALL clear on that same edge.
REQ-023 A recapture of an already-set mask bit SHALL update the digit only; the mask is unchanged.
REQ-024 An all-high or multi-low an SHALL never cause a capture.
REQ-025 Digits not being captured SHALL retain their values and valid bits.

Reset
REQ-026 While rst_n=0 at an edge, the block SHALL set: digits=16'h0000, digit_valid=4'b0000, err=0, frame_valid=0, mask=0, cnt=0, state=WAIT, sample register = {4'b1111, 7'b1111111}.
REQ-027 Reset asserted mid-COUNT SHALL abort the pending capture; no output pulse occurs on or after the reset edge.
REQ-028 After rst_n returns to 1, capture timing SHALL restart per REQ-016 from the first stable sample.

Verification
REQ-029 Scenario: STABLE_CYCLES=4; an=1110, seg=0000110 held from edge 10 -> digits[3:0]=3 and digit_valid[0]=1 at edge 14; no change at edges 15 and later.
REQ-030 Scenario: seg toggles every 2 cycles on digit 1 -> no capture occurs; digit_valid[1] stays 0 and err stays 0.
REQ-031 Scenario: scan digits 0..3 with 1,A,d,F, each held 6 cycles -> digits=16'hFdA1 (digit 3 = F), digit_valid=1111, and a single frame_valid pulse on the digit-3 capture edge.
REQ-032 Scenario: an=1101, seg=1111110 held -> err pulses exactly once, digit_valid[1]=0, digit value unchanged; then seg=1111111 -> no err pulse.
REQ-033 Scenario: an=1100 held 20 cycles, then an=1111 -> no capture and no pulse.
REQ-034 Scenario: rst_n=0 at edge 12 of a stable pattern started at edge 10 -> no capture; all outputs at reset values until 4 cycles after the first stable post-reset sample.

Source files
------------

// File: rtl/display7seg_reader.sv
// Samples a multiplexed active-low 4-digit 7-segment bus, waits for each
// (an, segment) pair to settle, and decodes it into per-digit hex values.
module display7seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        err,
  output logic        frame_valid
);

  typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;

  state_t      state, state_nx;
  logic [10:0] samp, prev;
  logic [7:0]  cnt, cnt_nx;
  logic [3:0]  mask;
  logic [3:0]  sel;
  logic        same, onehot, capture;
  logic [3:0]  dec_val;
  logic        dec_ok, blank;

  assign same = (samp == prev);
  assign sel  = ~samp[10:7];

  always_comb begin
    onehot = 1'b0;
    case (samp[10:7])
      4'b1110, 4'b1101, 4'b1011, 4'b0111: onehot = 1'b1;
      default:                            onehot = 1'b0;
    endcase
  end

  always_comb begin
    dec_val = 4'h0;
    dec_ok  = 1'b1;
    blank   = 1'b0;
    case (samp[6:0])
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      7'b1111111: begin dec_ok = 1'b0; blank = 1'b1; end
      default:    dec_ok = 1'b0;
    endcase
  end

  // cnt counts cycles the current sample has been seen; the capture edge is
  // the one on which it would reach STABLE_CYCLES.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      WAIT: begin
        if (onehot) begin
          state_nx = COUNT;
          cnt_nx   = 8'd1;
        end else begin
          cnt_nx   = '0;
        end
      end
      COUNT, HELD: begin
        if (!same) begin
          if (onehot) begin
            state_nx = COUNT;
            cnt_nx   = 8'd1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = '0;
          end
        end else if (state == COUNT) begin
          cnt_nx = cnt + 8'd1;
          if ({1'b0, cnt} + 9'd1 >= 9'(STABLE_CYCLES)) begin
            capture  = 1'b1;
            state_nx = HELD;
          end
        end
      end
      default: begin
        state_nx = WAIT;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp        <= '1;
      prev        <= '1;
      state       <= WAIT;
      cnt         <= '0;
      mask        <= '0;
      digits      <= '0;
      digit_valid <= '0;
      err         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      samp        <= {an, a, b, c, d, e, f, g};
      prev        <= samp;
      state       <= state_nx;
      cnt         <= cnt_nx;
      err         <= 1'b0;
      frame_valid <= 1'b0;
      if (capture) begin
        if (dec_ok) begin
          digit_valid <= digit_valid | sel;
          for (int unsigned i = 0; i < 4; i++)
            if (sel[i]) digits[4*i +: 4] <= dec_val;
        end else begin
          digit_valid <= digit_valid & ~sel;
          err         <= ~blank;
        end
        if ((mask | sel) == 4'b1111) begin
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask        <= mask | sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_display7seg_reader.sv
// Directed bench for display7seg_reader: table of held patterns plus
// hand-written latency, toggling and mid-count reset sequences.
module tb_display7seg_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        err, frame_valid;

  int errors = 0;
  int checks = 0;

  display7seg_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .an(an), .digits(digits), .digit_valid(digit_valid),
    .err(err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] dig;
    logic [3:0]  val;
    int          errs;
    int          frames;
  } vec_t;

  vec_t vt[24];
  int   nvec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one rising edge; outputs are then looked at 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".digits"}, 32'(digits), 32'h0);
    chk({name, ".valid"}, 32'(digit_valid), 32'h0);
    chk({name, ".err"}, 32'(err), 32'h0);
    chk({name, ".fv"}, 32'(frame_valid), 32'h0);
  endtask

  initial begin
    int ec, fc;
    nvec = 0;
    vt[nvec++] = '{4'b1110, 7'b1001111, 6, 16'h0001, 4'b0001, 0, 0};
    vt[nvec++] = '{4'b1101, 7'b0001000, 6, 16'h00A1, 4'b0011, 0, 0};
    vt[nvec++] = '{4'b1011, 7'b1000010, 6, 16'h0DA1, 4'b0111, 0, 0};
    vt[nvec++] = '{4'b0111, 7'b0111000, 6, 16'hFDA1, 4'b1111, 0, 1};
    vt[nvec++] = '{4'b1100, 7'b0000000, 20, 16'hFDA1, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1111, 7'b0000000, 6, 16'hFDA1, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1101, 7'b1111110, 6, 16'hFDA1, 4'b1101, 1, 0};
    vt[nvec++] = '{4'b1101, 7'b1111111, 6, 16'hFDA1, 4'b1101, 0, 0};
    vt[nvec++] = '{4'b1110, 7'b0000000, 6, 16'hFDA8, 4'b1101, 0, 0};
    vt[nvec++] = '{4'b1011, 7'b0100100, 6, 16'hF5A8, 4'b1101, 0, 0};
    vt[nvec++] = '{4'b0111, 7'b0110001, 6, 16'hC5A8, 4'b1101, 0, 1};
    vt[nvec++] = '{4'b1101, 7'b1100000, 6, 16'hC5B8, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1101, 7'b0100000, 6, 16'hC568, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1110, 7'b0000100, 6, 16'hC569, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1011, 7'b0010010, 6, 16'hC269, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b0111, 7'b0110000, 6, 16'hE269, 4'b1111, 0, 1};
    vt[nvec++] = '{4'b1110, 7'b0001111, 6, 16'hE267, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1110, 7'b1001100, 6, 16'hE264, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1110, 7'b0000001, 6, 16'hE260, 4'b1111, 0, 0};
    vt[nvec++] = '{4'b1101, 7'b1111111, 6, 16'hE260, 4'b1101, 0, 0};

    // reset state
    rst_n = 1'b0; an = 4'b1111; seg = 7'b1111111;
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick(); tick();

    // latency: pair sampled at edge k, captured exactly at edge k+4
    an = 4'b1110; seg = 7'b0000110;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("lat.pre%0d", i), 32'(digit_valid), 32'h0);
    end
    tick();
    chk("lat.digits", 32'(digits), 32'h0003);
    chk("lat.valid", 32'(digit_valid), 32'h1);
    chk("lat.err", 32'(err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lat.post%0d", i), 32'({digits, digit_valid, err, frame_valid}),
          32'({16'h0003, 4'b0001, 1'b0, 1'b0}));
    end

    // table vectors
    for (int v = 0; v < nvec; v++) begin
      an = vt[v].an; seg = vt[v].seg;
      ec = 0; fc = 0;
      for (int c = 0; c < vt[v].hold; c++) begin
        tick();
        if (err) ec++;
        if (frame_valid) fc++;
      end
      chk($sformatf("vec%0d.digits", v), 32'(digits), 32'(vt[v].dig));
      chk($sformatf("vec%0d.valid", v), 32'(digit_valid), 32'(vt[v].val));
      chk($sformatf("vec%0d.errs", v), 32'(ec), 32'(vt[v].errs));
      chk($sformatf("vec%0d.frames", v), 32'(fc), 32'(vt[v].frames));
    end

    // segments toggling every 2 cycles on digit 1 never settle
    ec = 0;
    for (int c = 0; c < 20; c++) begin
      an = 4'b1101;
      seg = ((c / 2) % 2 == 0) ? 7'b1001111 : 7'b0001111;
      tick();
      if (err || frame_valid) ec++;
    end
    chk("toggle.valid", 32'(digit_valid), 32'b1101);
    chk("toggle.digits", 32'(digits), 32'hE260);
    chk("toggle.pulses", 32'(ec), 32'h0);

    // reset asserted two edges into a stable pattern aborts the capture
    an = 4'b1110; seg = 7'b0000110;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rst.edge");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_reset_vals($sformatf("rst.wait%0d", i));
    end
    tick();
    chk("rst.cap.digits", 32'(digits), 32'h0003);
    chk("rst.cap.valid", 32'(digit_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
